// File: rtl/ex_muldiv_seq.sv
// Iterative signed multiply/divide engine for the execute stage: one bit per cycle,
// a sign-fixup cycle, then a one-cycle done pulse with the full double-width result.
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             cache_done,
    input  logic             flush,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [5:0] FUNC_MULT = 6'b011000;
    localparam logic [5:0] FUNC_DIV  = 6'b011010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_reg;
    logic [CW-1:0]      count_reg;
    logic               is_div_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    // mult: running product; div: {partial remainder, quotient/dividend bits}
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   result_lo_reg;
    logic [WIDTH-1:0]   result_hi_reg;
    logic               dz_reg;

    logic               is_mult_req;
    logic               is_div_req;
    logic               can_accept;
    logic               dz_req;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mult_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    always_comb begin
        is_mult_req = (func == FUNC_MULT);
        is_div_req  = (func == FUNC_DIV);
        dz_req      = is_div_req && (input2 == '0);
        can_accept  = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) &&
                      start && cache_done && !flush && (is_mult_req || is_div_req);
        // -2^31 maps to 0x80000000, which is the correct unsigned magnitude
        abs1 = input1[WIDTH-1] ? -input1 : input1;
        abs2 = input2[WIDTH-1] ? -input2 : input2;
    end

    always_comb begin
        add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        mult_next = {add_sum, acc_reg[WIDTH-1:1]};

        // Extra top bit lets the trial difference flag a borrow even when remainder >= 2^(W-1)
        trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {1'b0, b_reg};
        if (!trial[WIDTH])
            div_next = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
            div_next = {acc_reg[2*WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod_signed = neg_res_reg ? -acc_reg : acc_reg;
        quo_signed  = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_signed  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            is_div_reg    <= 1'b0;
            neg_res_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
            dz_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (can_accept) begin
                        if (dz_req) begin
                            result_lo_reg <= '1;
                            result_hi_reg <= input1;
                            dz_reg        <= 1'b1;
                            state_reg     <= ST_DONE;
                        end else begin
                            is_div_reg  <= is_div_req;
                            neg_res_reg <= input1[WIDTH-1] ^ input2[WIDTH-1];
                            neg_rem_reg <= input1[WIDTH-1];
                            a_reg       <= abs1;
                            b_reg       <= abs2;
                            acc_reg     <= is_div_req ? {{WIDTH{1'b0}}, abs1}
                                                      : {{WIDTH{1'b0}}, abs2};
                            count_reg   <= '0;
                            state_reg   <= ST_RUN;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg   <= is_div_reg ? div_next : mult_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_ITER)
                            state_reg <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        if (is_div_reg) begin
                            result_lo_reg <= quo_signed;
                            result_hi_reg <= rem_signed;
                        end else begin
                            result_lo_reg <= prod_signed[WIDTH-1:0];
                            result_hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
                        end
                        dz_reg    <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == ST_RUN) || (state_reg == ST_SIGN);
    assign done        = (state_reg == ST_DONE);
    assign result_lo   = result_lo_reg;
    assign result_hi   = result_hi_reg;
    assign div_by_zero = dz_reg;

endmodule
